// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
// Memory-side responder for the system bus. It serves one request at a time:
// cache-line reads (8 x 64b beats, critical word first, wrapping inside the 64B line)
// and cache-line writebacks (8 beats written from the line base). Backed by an
// internal 64-bit word array whose contents survive reset.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   bus_reqcyc_i   request / write-data valid from initiator
//   bus_req_i      request address, then write data beats
//   bus_reqtag_i   [12]=1 write / 0 read, [11:8] device code, rest opaque
//   bus_respack_i  initiator accepts the current read beat
//   bus_reqack_o   one-cycle request acceptance pulse
//   bus_respcyc_o  read beat valid
//   bus_resp_o     read beat data
//   bus_resptag_o  echo of the accepted tag during read beats, 0 otherwise
module sysbus_mem_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned READ_LATENCY   = 4,
    parameter logic [3:0]  MEM_DEV_ID     = 4'h1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc_i,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req_i,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_i,
    input  logic                      bus_respack_i,
    output logic                      bus_reqack_o,
    output logic                      bus_respcyc_o,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp_o,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag_o
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned LatW = $clog2(READ_LATENCY + 1);
    // Outputs are registered from the next state, so the wait state lasts
    // READ_LATENCY-1 cycles to put the first beat READ_LATENCY cycles after reqack.
    localparam logic [LatW-1:0] LatInit =
        LatW'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);

    typedef enum logic [2:0] {
        StIdle,
        StAck,
        StRdWait,
        StRdBurst,
        StWrBurst
    } state_e;

    state_e                    state_q, state_d;
    logic [AW-1:0]             addr_q, addr_d;     // latched word index
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [LatW-1:0]           lat_q, lat_d;
    logic [2:0]                beat_q, beat_d;

    logic                      reqack_q, reqack_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

    logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic                      wr_en;
    logic [AW-1:0]             wr_idx;
    logic [AW-1:0]             rd_idx;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        wr_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_reqcyc_i && (bus_reqtag_i[11:8] == MEM_DEV_ID)) begin
                    addr_d  = bus_req_i[AW+2:3];
                    tag_d   = bus_reqtag_i;
                    state_d = StAck;
                end
            end
            StAck: begin
                beat_d = 3'd0;
                if (tag_q[12]) begin
                    state_d = StWrBurst;
                end else if (READ_LATENCY <= 1) begin
                    state_d = StRdBurst;
                end else begin
                    state_d = StRdWait;
                    lat_d   = LatInit;
                end
            end
            StRdWait: begin
                if (lat_q == '0) begin
                    state_d = StRdBurst;
                    beat_d  = 3'd0;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StRdBurst: begin
                if (bus_respack_i) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrBurst: begin
                // Cycles without reqcyc are initiator wait states.
                if (bus_reqcyc_i) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Writebacks are line-aligned; critical-word-first reads wrap inside the line.
    assign wr_idx = {addr_q[AW-1:3], beat_q};
    assign rd_idx = {addr_q[AW-1:3], addr_q[2:0] + beat_d};

    always_comb begin
        reqack_d  = (state_d == StAck);
        respcyc_d = (state_d == StRdBurst);
        resp_d    = respcyc_d ? mem_q[rd_idx] : '0;
        resptag_d = respcyc_d ? tag_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            tag_q     <= '0;
            lat_q     <= '0;
            beat_q    <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            lat_q     <= lat_d;
            beat_q    <= beat_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    // Backing store is not reset; a reset mid-writeback simply stops the writes.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= bus_req_i;
        end
    end

    assign bus_reqack_o  = reqack_q;
    assign bus_respcyc_o = respcyc_q;
    assign bus_resp_o    = resp_q;
    assign bus_resptag_o = resptag_q;

endmodule
